zb_chip_spreader: RTL

Parametrised IEEE 802.15.4 (2.4 GHz) symbol-to-chip spreader placed between the TX symbol FIFO and the MUX/DEMUX routing fabric of TOP. It buffers 4-bit symbols and maps each one to its 32-chip PN sequence. It then serialises the chips at a programmable number of clocks per chip, optionally split into O-QPSK I/Q rails. It adds flow control, a symbol counter and a compile-time modulation mode.

---
 rtl/zb_pkg.sv | 31 +++
 rtl/zb_chip_spreader_if.sv | 33 +++
 rtl/zb_chip_spreader_fifo.sv | 60 ++++++
 rtl/zb_chip_spreader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/zb_pkg.sv
// Shared constants, state encoding and symbol-to-chip mapping for the
// IEEE 802.15.4 2.4 GHz chip spreader.
package zb_pkg;

  localparam logic [31:0] ZB_CHIP_BASE = 32'hD9C3522E;
  localparam logic [31:0] ZB_ODD_MASK  = 32'h55555555;
  localparam int unsigned ZB_SYM_W     = 4;
  localparam int unsigned ZB_CHIPS     = 32;
  localparam int unsigned ZB_IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Symbols 0-7 rotate the base right by 4*s; symbols 8-15 additionally invert odd chips.
  function automatic logic [31:0] zb_chip_word(input logic [3:0] sym);
    logic [63:0] dbl;
    logic [4:0]  rot;
    logic [31:0] word;
    rot  = {sym[2:0], 2'b00};
    dbl  = {ZB_CHIP_BASE, ZB_CHIP_BASE} >> rot;
    word = dbl[31:0];
    if (sym[3]) begin
      word = word ^ ZB_ODD_MASK;
    end
    return word;
  endfunction

endpackage

// File: rtl/zb_chip_spreader_if.sv
// Symbol-in / chip-out bundle of the chip spreader; slave is the spreader side.
interface zb_chip_spreader_if #(
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned CNT_W     = 16
);
  localparam int unsigned LVL_W = $clog2(BUF_DEPTH) + 1;

  logic             inEnable;
  logic             inClear;
  logic             inSymValid;
  logic [3:0]       inSymbol;
  logic             outSymReady;
  logic [LVL_W-1:0] outLevel;
  logic             outChipValid;
  logic             outChipStrobe;
  logic             outChipI;
  logic             outChipQ;
  logic             outBusy;
  logic             outDone;
  logic [CNT_W-1:0] outSymCount;

  modport slave (
    input  inEnable, inClear, inSymValid, inSymbol,
    output outSymReady, outLevel, outChipValid, outChipStrobe,
           outChipI, outChipQ, outBusy, outDone, outSymCount
  );

  modport master (
    output inEnable, inClear, inSymValid, inSymbol,
    input  outSymReady, outLevel, outChipValid, outChipStrobe,
           outChipI, outChipQ, outBusy, outDone, outSymCount
  );
endinterface

// File: rtl/zb_chip_spreader_fifo.sv
// Symbol buffer: show-ahead FIFO with registered level/full/empty flags.
module zb_sym_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_n;

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    level_n = level;
    case ({do_push, do_pop})
      2'b10:   level_n = level + LVL_W'(1);
      2'b01:   level_n = level - LVL_W'(1);
      default: level_n = level;
    endcase
  end

  // Reset flushes by clearing pointers; storage itself needs no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_n;
      full  <= (level_n == LVL_W'(DEPTH));
      empty <= (level_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/zb_chip_spreader.sv
// 802.15.4 symbol-to-chip spreader: buffers symbols, serialises 32-chip PN words.
// Optional O-QPSK I/Q rail split enabled by defining ZB_SPREADER_OQPSK_EN.
module zb_chip_spreader
  import zb_pkg::*;
#(
  parameter int unsigned CHIP_DIV  = 4,
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                inClock,
  input  logic                inReset,
  zb_chip_spreader_if.slave   bus
);
  localparam int unsigned DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam int unsigned LVL_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CHIP_DIV - 1);
  localparam logic [ZB_IDX_W-1:0] IDX_LAST = ZB_IDX_W'(ZB_CHIPS - 1);

  state_t               state, state_n;
  logic [31:0]          word, word_n;
  logic [ZB_IDX_W-1:0]  chip_idx, chip_idx_n;
  logic [DIV_W-1:0]     div_cnt, div_n;
  logic                 chip_valid, valid_n;
  logic                 chip_strobe, strobe_n;
  logic                 chip_i, i_n;
  logic                 chip_q, q_n;
  logic                 done, done_n;
  logic                 busy;
  logic [CNT_W-1:0]     sym_count, cnt_n;
  logic                 pop;
  logic                 emit;
  logic                 sym_done;
  logic                 start_ok;

  logic [ZB_SYM_W-1:0]  fifo_dout;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_full;
  logic                 fifo_empty;

  zb_sym_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ZB_SYM_W)
  ) u_fifo (
    .clk   (inClock),
    .rst   (inReset),
    .push  (bus.inSymValid & ~fifo_full),
    .din   (bus.inSymbol),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign start_ok = ~fifo_empty & bus.inEnable;

  // Next state, chip shifter, divider and registered-output next values.
  always_comb begin
    state_n    = state;
    word_n     = word;
    chip_idx_n = chip_idx;
    div_n      = div_cnt;
    valid_n    = chip_valid;
    strobe_n   = 1'b0;
    i_n        = chip_i;
    q_n        = chip_q;
    done_n     = 1'b0;
    pop        = 1'b0;
    emit       = 1'b0;
    sym_done   = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) state_n = LOAD;
      end
      LOAD: begin
        pop        = 1'b1;
        word_n     = zb_chip_word(fifo_dout);
        chip_idx_n = '0;
        div_n      = '0;
        emit       = 1'b1;
        state_n    = RUN;
      end
      RUN: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + DIV_W'(1);
        end else if (chip_idx != IDX_LAST) begin
          word_n     = {word[30:0], 1'b0};
          chip_idx_n = chip_idx + ZB_IDX_W'(1);
          div_n      = '0;
          emit       = 1'b1;
        end else begin
          sym_done = 1'b1;
          div_n    = '0;
          // Reload in the same cycle so back-to-back symbols have no gap.
          if (start_ok) begin
            pop        = 1'b1;
            word_n     = zb_chip_word(fifo_dout);
            chip_idx_n = '0;
            emit       = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            i_n     = 1'b0;
            q_n     = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (emit) begin
      valid_n  = 1'b1;
      strobe_n = 1'b1;
`ifdef ZB_SPREADER_OQPSK_EN
      // Even chips drive I, odd chips drive Q; each holds across two chip periods.
      if (chip_idx_n[0]) q_n = word_n[31];
      else               i_n = word_n[31];
`else
      i_n = word_n[31];
`endif
    end

`ifndef ZB_SPREADER_OQPSK_EN
    q_n = 1'b0;
`endif

    cnt_n = sym_count;
    if (bus.inClear) begin
      cnt_n = '0;
    end else if (sym_done && (sym_count != {CNT_W{1'b1}})) begin
      cnt_n = sym_count + CNT_W'(1);
    end
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state       <= IDLE;
      word        <= '0;
      chip_idx    <= '0;
      div_cnt     <= '0;
      chip_valid  <= 1'b0;
      chip_strobe <= 1'b0;
      chip_i      <= 1'b0;
      chip_q      <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      sym_count   <= '0;
    end else begin
      state       <= state_n;
      word        <= word_n;
      chip_idx    <= chip_idx_n;
      div_cnt     <= div_n;
      chip_valid  <= valid_n;
      chip_strobe <= strobe_n;
      chip_i      <= i_n;
      chip_q      <= q_n;
      done        <= done_n;
      busy        <= (state_n != IDLE);
      sym_count   <= cnt_n;
    end
  end

  assign bus.outSymReady   = ~fifo_full;
  assign bus.outLevel      = fifo_level;
  assign bus.outChipValid  = chip_valid;
  assign bus.outChipStrobe = chip_strobe;
  assign bus.outChipI      = chip_i;
  assign bus.outChipQ      = chip_q;
  assign bus.outBusy       = busy;
  assign bus.outDone       = done;
  assign bus.outSymCount   = sym_count;

endmodule
